uart_rx_ctrl: RTL and testbench

//  UART receive sequencer. Watches the serial line for a start edge and drives

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rx_h2l_detect.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- constants shared by the UART RX/TX blocks and their benches.
//   BPS_FULL / BPS_HALF : baud counter terminal / mid-bit values (9600 bps @ 50 MHz)
//   ST_*                : RX sequencer state encodings (binary)
//   rx_counting()       : states in which the baud generator must run
package uart_pkg;

  localparam int BPS_FULL = 5208;
  localparam int BPS_HALF = 2604;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic logic rx_counting(input logic [2:0] st);
    return (st == ST_START) || (st == ST_DATA) || (st == ST_PARITY) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/rx_h2l_detect.sv
// rx_h2l_detect -- brings the raw RX pin into the CLK domain and flags
// high-to-low transitions.
//   CLK, RSTn : clock, async active-low reset
//   Pin_In    : raw serial line (asynchronous)
//   Pin_Sync  : synchronised line level
//   H2L_Sig   : 1 for one cycle after the synchronised line falls
module rx_h2l_detect (
  input  logic CLK,
  input  logic RSTn,
  input  logic Pin_In,
  output logic H2L_Sig,
  output logic Pin_Sync
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], Pin_In};
      prev_q <= sync_q[1];
    end
  end

  assign Pin_Sync = sync_q[1];
  assign H2L_Sig  = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive sequencer. Detects a start edge, runs the peer
// baud generator via Count_Sig, samples one bit per BPS_CLK strobe and
// assembles start / data (LSB first) / optional parity / stop.
//   CLK, RSTn   : clock, async active-low reset
//   RX_Pin_In   : raw serial line, idle high
//   Rx_En_Sig   : accept new frames (checked only at the start edge)
//   BPS_CLK     : mid-bit strobe from the baud generator
//   Count_Sig   : run request to the baud generator
//   Rx_Data     : last received data word
//   Rx_Done_Sig : one-cycle frame-complete pulse
//   Frame_Err   : stop bit was 0 (held until next done)
//   Parity_Err  : parity mismatch (held until next done)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 Rx_En_Sig,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Done_Sig,
  output logic                 Frame_Err,
  output logic                 Parity_Err
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       PAR_ON   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  logic                 h2l;
  logic                 pin_sync;
  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;

  rx_h2l_detect u_h2l (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Pin_In   (RX_Pin_In),
    .H2L_Sig  (h2l),
    .Pin_Sync (pin_sync)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      Count_Sig   <= 1'b0;
      bit_cnt     <= 3'd0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      Rx_Data     <= '0;
      Rx_Done_Sig <= 1'b0;
      Frame_Err   <= 1'b0;
      Parity_Err  <= 1'b0;
    end else begin
      Rx_Done_Sig <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (h2l && Rx_En_Sig) begin
            state     <= ST_START;
            Count_Sig <= 1'b1;
          end
        end
        ST_START: begin
          if (BPS_CLK) begin
            // A line already back high at mid start bit was noise: drop it quietly.
            if (pin_sync) begin
              state     <= ST_IDLE;
              Count_Sig <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (BPS_CLK) begin
            // Wire order is LSB first, so after DATA_BITS shifts bit 0 holds the first sample.
            shift_q <= {pin_sync, shift_q[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT)
              state <= PAR_ON ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (BPS_CLK) begin
            perr_q <= (^{shift_q, pin_sync}) ^ PAR_ODD;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Outputs load here so they are already valid while Rx_Done_Sig is high in DONE.
          if (BPS_CLK) begin
            Rx_Data     <= shift_q;
            Frame_Err   <= ~pin_sync;
            Parity_Err  <= PAR_ON & perr_q;
            Rx_Done_Sig <= 1'b1;
            Count_Sig   <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          Count_Sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed bench for uart_rx_ctrl. Two instances share
// clock/reset: dut_a is 8N1, dut_b is 8E1. A small baud model per instance
// uses a shortened bit period to keep runtime short.
module tb_uart_rx_ctrl;

  localparam int BIT  = 32;
  localparam int HALF = 16;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  logic en   = 1'b0;
  logic pin_a = 1'b1, pin_b = 1'b1;
  logic cs_a, cs_b, bps_a, bps_b;
  logic done_a, done_b, ferr_a, ferr_b, perr_a, perr_b;
  logic [7:0] data_a, data_b;
  int cnt_a, cnt_b;

  always #5 CLK = ~CLK;

  // Baud model: holds 0 while idle, free-runs and wraps while Count_Sig is high.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      cnt_a <= !cs_a ? 0 : (cnt_a == BIT-1) ? 0 : cnt_a + 1;
      cnt_b <= !cs_b ? 0 : (cnt_b == BIT-1) ? 0 : cnt_b + 1;
    end
  end
  assign bps_a = cs_a && (cnt_a == HALF);
  assign bps_b = cs_b && (cnt_b == HALF);

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(pin_a), .Rx_En_Sig(en), .BPS_CLK(bps_a),
    .Count_Sig(cs_a), .Rx_Data(data_a), .Rx_Done_Sig(done_a),
    .Frame_Err(ferr_a), .Parity_Err(perr_a)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(pin_b), .Rx_En_Sig(en), .BPS_CLK(bps_b),
    .Count_Sig(cs_b), .Rx_Data(data_b), .Rx_Done_Sig(done_b),
    .Frame_Err(ferr_b), .Parity_Err(perr_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       p;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];

  always @(negedge CLK) begin
    if (done_a) qa.push_back('{data_a, ferr_a, perr_a});
    if (done_b) qb.push_back('{data_b, ferr_b, perr_b});
  end

  typedef struct {
    bit         dut;      // 0 = dut_a (8N1), 1 = dut_b (8E1)
    logic [7:0] d;
    logic       par;      // parity bit on the wire (dut_b only)
    logic       stop;
    logic       en;
    bit         en_drop;  // drop Rx_En_Sig after the start bit
    int         idle;     // idle-high cycles after the frame
    int         exp_done;
    logic       exp_f;
    logic       exp_p;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit b, input logic v);
    if (b) pin_b = v;
    else   pin_a = v;
  endtask

  task automatic send(input vec_t v);
    en = v.en;
    drive(v.dut, 1'b0);
    wait_cyc(BIT);
    if (v.en_drop) en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(v.dut, v.d[i]);
      wait_cyc(BIT);
    end
    if (v.dut) begin
      drive(1'b1, v.par);
      wait_cyc(BIT);
    end
    drive(v.dut, v.stop);
    wait_cyc(BIT);
    if (v.idle > 0) begin
      drive(v.dut, 1'b1);
      wait_cyc(v.idle);
    end
  endtask

  task automatic frame_check(input string tag, input vec_t v);
    rec_t r;
    int   n;
    n = v.dut ? qb.size() : qa.size();
    check({tag, "_done_cnt"}, n, v.exp_done);
    if (n > 0) begin
      if (v.dut) r = qb.pop_front();
      else       r = qa.pop_front();
      check({tag, "_data"}, {24'd0, r.d}, {24'd0, v.d});
      check({tag, "_ferr"}, {31'd0, r.f}, {31'd0, v.exp_f});
      check({tag, "_perr"}, {31'd0, r.p}, {31'd0, v.exp_p});
    end
    check({tag, "_count_sig"}, {31'd0, v.dut ? cs_b : cs_a}, 32'd0);
    qa.delete();
    qb.delete();
  endtask

  vec_t tbl[10];
  vec_t v81;

  initial begin
    //            dut  data    par  stop en  drop idle    done f  p
    tbl[0] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 2*BIT, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0,     0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'hC6, 1'b0, 1'b1, 1'b1, 1'b1, BIT,   1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 0,     1, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, BIT,   1, 1'b0, 1'b0};
    v81    = '{1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, BIT,   1, 1'b0, 1'b0};

    // Reset state
    wait_cyc(3);
    check("rst_data_a", {24'd0, data_a}, 32'd0);
    check("rst_cs_a",   {31'd0, cs_a},   32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_ferr_a", {31'd0, ferr_a}, 32'd0);
    check("rst_perr_b", {31'd0, perr_b}, 32'd0);
    RSTn = 1'b1;
    wait_cyc(4);
    en = 1'b1;

    // Frames back to back unless an entry asks for idle afterwards
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      frame_check($sformatf("v%0d", i), tbl[i]);
    end

    // Short low pulse: baud runs, start sample sees high, everything drops back
    en = 1'b1;
    pin_a = 1'b0;
    wait_cyc(6);
    pin_a = 1'b1;
    wait_cyc(6);
    check("glitch_cs_started", {31'd0, cs_a}, 32'd1);
    wait_cyc(20);
    check("glitch_cs_dropped", {31'd0, cs_a}, 32'd0);
    check("glitch_no_done", qa.size(), 32'd0);
    check("glitch_data_kept", {24'd0, data_a}, 32'hC6);
    wait_cyc(BIT);

    // Reset in the middle of data bit 4
    pin_a = 1'b0;
    wait_cyc(BIT);
    wait_cyc(4*BIT);
    wait_cyc(HALF);
    check("pre_rst_cs", {31'd0, cs_a}, 32'd1);
    RSTn = 1'b0;
    #1;
    check("midrst_data", {24'd0, data_a}, 32'd0);
    check("midrst_cs",   {31'd0, cs_a},   32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    check("midrst_ferr", {31'd0, ferr_a}, 32'd0);
    pin_a = 1'b1;
    wait_cyc(4);
    RSTn = 1'b1;
    wait_cyc(BIT);
    check("post_rst_no_done", qa.size(), 32'd0);
    check("post_rst_cs", {31'd0, cs_a}, 32'd0);
    send(v81);
    frame_check("after_rst", v81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
